// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO 7-segment scan path.
// Segment patterns are active-low with bit7 = a down to bit0 = dp.
package gpio_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_e;

    localparam int unsigned SEG_BIT_A  = 7;
    localparam int unsigned SEG_BIT_B  = 6;
    localparam int unsigned SEG_BIT_C  = 5;
    localparam int unsigned SEG_BIT_D  = 4;
    localparam int unsigned SEG_BIT_E  = 3;
    localparam int unsigned SEG_BIT_F  = 2;
    localparam int unsigned SEG_BIT_G  = 1;
    localparam int unsigned SEG_BIT_DP = 0;

endpackage

// File: rtl/gpio_scan_timer.sv
// Blank/on sequencer for the multiplexed display: digit index, phase counter and frame-load strobe.
// Exports next-state values so the top can register its outputs on the same edge as the state change.
// With GPIO_SEG_SCAN_DIM_EN it also exports the BLANK->ON entry strobe used to restart the PWM.
module gpio_scan_timer
    import gpio_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 1024,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [0:0] state_d,
    output logic [2:0] idx_d,
`ifdef GPIO_SEG_SCAN_DIM_EN
    output logic       on_start,
`endif
    output logic       load
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0]    ST_BLANK   = BLANK;
    localparam logic [0:0]    ST_ON      = ON;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [0:0]    state_q;
    logic [2:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          enter_on;

    // Dropping enable parks the scan exactly where reset leaves it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CW'(1);
        enter_on = 1'b0;
        load     = 1'b0;
        if (!enable) begin
            state_d = ST_BLANK;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d  = ST_ON;
                cnt_d    = '0;
                enter_on = 1'b1;
                load     = (idx_q == 3'd0);
            end
        end else begin
            if (cnt_q == DIGIT_LAST) begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

`ifdef GPIO_SEG_SCAN_DIM_EN
    assign on_start = enter_on;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_BLANK;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_seg_scan.sv
// Common-anode 7-segment scanner: per-frame pattern snapshot, blanking gaps, registered outputs.
// Define GPIO_SEG_SCAN_DIM_EN to add the 4-bit dim input and per-digit PWM brightness.
module gpio_seg_scan
    import gpio_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 1024,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] seg_0,
    input  logic [7:0] seg_1,
    input  logic [7:0] seg_2,
    input  logic [7:0] seg_3,
    input  logic [7:0] seg_4,
    input  logic [7:0] seg_5,
    input  logic [7:0] seg_6,
    input  logic [7:0] seg_7,
`ifdef GPIO_SEG_SCAN_DIM_EN
    input  logic [3:0] dim,
`endif
    output logic [7:0] seg_out,
    output logic [7:0] an_n,
    output logic       frame_tick
);

    logic [0:0] state_d;
    logic [2:0] idx_d;
    logic       load;

    logic [7:0] shadow_q [8];
    logic [7:0] shadow_d [8];
    logic [7:0] seg_out_q, seg_out_d;
    logic [7:0] an_n_q, an_n_d;
    logic       frame_tick_q, frame_tick_d;
    logic       lit;

`ifdef GPIO_SEG_SCAN_DIM_EN
    logic       on_start;
    logic [3:0] pwm_q, pwm_d;
`endif

    gpio_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .state_d (state_d),
        .idx_d   (idx_d),
`ifdef GPIO_SEG_SCAN_DIM_EN
        .on_start(on_start),
`endif
        .load    (load)
    );

    // Outputs are computed from next-state values so they flip on the same edge as the FSM.
    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d[0] = seg_0;
            shadow_d[1] = seg_1;
            shadow_d[2] = seg_2;
            shadow_d[3] = seg_3;
            shadow_d[4] = seg_4;
            shadow_d[5] = seg_5;
            shadow_d[6] = seg_6;
            shadow_d[7] = seg_7;
        end
`ifdef GPIO_SEG_SCAN_DIM_EN
        pwm_d = on_start ? 4'd0 : pwm_q + 4'd1;
        lit   = (state_d == ON) && (pwm_d <= dim);
`else
        lit   = (state_d == ON);
`endif
        seg_out_d    = SEG_OFF;
        an_n_d       = AN_OFF;
        frame_tick_d = load;
        if (lit) begin
            an_n_d    = ~(8'b1 << idx_d);
            seg_out_d = shadow_d[idx_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q     <= '{default: SEG_OFF};
            seg_out_q    <= SEG_OFF;
            an_n_q       <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            seg_out_q    <= seg_out_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef GPIO_SEG_SCAN_DIM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    assign seg_out    = seg_out_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_gpio_seg_scan.sv
// Directed bench for gpio_seg_scan with DIGIT_CYCLES=16, BLANK_CYCLES=2 (144-cycle frame).
// Each cycle is also checked against a small frame-position model; dim steps need GPIO_SEG_SCAN_DIM_EN.
module tb_gpio_seg_scan;

    localparam int ND     = 8;
    localparam int DC     = 16;
    localparam int BC     = 2;
    localparam int SLOT   = DC + BC;
    localparam int FRAME  = ND * SLOT;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] seg_in [8];
    logic [3:0] dim;
    logic [7:0] seg_out;
    logic [7:0] an_n;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int base   = 0;
    logic [7:0] sh_m [8];

    gpio_seg_scan #(
        .NUM_DIGITS  (ND),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .seg_0     (seg_in[0]),
        .seg_1     (seg_in[1]),
        .seg_2     (seg_in[2]),
        .seg_3     (seg_in[3]),
        .seg_4     (seg_in[4]),
        .seg_5     (seg_in[5]),
        .seg_6     (seg_in[6]),
        .seg_7     (seg_in[7]),
`ifdef GPIO_SEG_SCAN_DIM_EN
        .dim       (dim),
`endif
        .seg_out   (seg_out),
        .an_n      (an_n),
        .frame_tick(frame_tick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [7:0] exp_an,
                               input logic [7:0] exp_seg, input logic exp_tick);
        checks++;
        assert (an_n === exp_an) else begin
            errors++;
            $error("[TB] FAIL %s an_n: observed %h expected %h", tag, an_n, exp_an);
        end
        checks++;
        assert (seg_out === exp_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg_out: observed %h expected %h", tag, seg_out, exp_seg);
        end
        checks++;
        assert (frame_tick === exp_tick) else begin
            errors++;
            $error("[TB] FAIL %s frame_tick: observed %b expected %b", tag, frame_tick, exp_tick);
        end
    endtask

    // Advances n cycles, sampling 1 time unit after each edge against the frame-position model.
    task automatic applyStimulus(input int n);
        int rc, rel, d, off, dim_m;
        logic [7:0] e_an, e_seg;
        logic       e_tick;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            cycle++;
`ifdef GPIO_SEG_SCAN_DIM_EN
            dim_m = int'(dim);
`else
            dim_m = 15;
`endif
            e_an   = 8'hFF;
            e_seg  = 8'hFF;
            e_tick = 1'b0;
            if (reset || !enable) begin
                base = cycle;
            end else begin
                rc = cycle - base;
                if (rc >= BC) begin
                    rel = (rc - BC) % FRAME;
                    d   = rel / SLOT;
                    off = rel % SLOT;
                    if (rel == 0) begin
                        for (int i = 0; i < 8; i++) sh_m[i] = seg_in[i];
                        e_tick = 1'b1;
                    end
                    if (off < DC && off <= dim_m) begin
                        e_an  = ~(8'h01 << d);
                        e_seg = sh_m[d];
                    end
                end
            end
            checkOutput($sformatf("model_c%0d", cycle), e_an, e_seg, e_tick);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        dim    = 4'hF;
        seg_in = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
        for (int i = 0; i < 8; i++) sh_m[i] = 8'hFF;

        applyStimulus(3);
        checkOutput("reset", 8'hFF, 8'hFF, 1'b0);
        reset = 1'b0;

        applyStimulus(1);
        checkOutput("blank_c1", 8'hFF, 8'hFF, 1'b0);
        applyStimulus(1);
        checkOutput("first_lit_c2", 8'hFE, 8'h03, 1'b1);
        applyStimulus(15);
        checkOutput("last_lit_c17", 8'hFE, 8'h03, 1'b0);
        applyStimulus(1);
        checkOutput("gap_c18", 8'hFF, 8'hFF, 1'b0);
        applyStimulus(2);
        checkOutput("digit1_c20", 8'hFD, 8'h9F, 1'b0);

        applyStimulus(30);
        seg_in[0] = 8'h25;
        seg_in[5] = 8'h24;
        applyStimulus(42);
        checkOutput("no_tear_c92", 8'hDF, 8'h49, 1'b0);
        applyStimulus(36);
        checkOutput("digit7_c128", 8'h7F, 8'h1F, 1'b0);
        applyStimulus(15);
        checkOutput("digit7_c143", 8'h7F, 8'h1F, 1'b0);
        applyStimulus(1);
        checkOutput("wrap_gap_c144", 8'hFF, 8'hFF, 1'b0);
        applyStimulus(2);
        checkOutput("tick2_c146", 8'hFE, 8'h25, 1'b1);
        applyStimulus(90);
        checkOutput("reload_c236", 8'hDF, 8'h24, 1'b0);
        applyStimulus(54);
        checkOutput("tick3_c290", 8'hFE, 8'h25, 1'b1);

        applyStimulus(200);
        checkOutput("digit3_c490", 8'hF7, 8'h0D, 1'b0);
        enable    = 1'b0;
        seg_in[1] = 8'hF3;
        applyStimulus(1);
        checkOutput("en_drop", 8'hFF, 8'hFF, 1'b0);
        applyStimulus(3);
        checkOutput("en_low_hold", 8'hFF, 8'hFF, 1'b0);
        enable = 1'b1;
        applyStimulus(1);
        checkOutput("reen_blank1", 8'hFF, 8'hFF, 1'b0);
        applyStimulus(1);
        checkOutput("reen_tick", 8'hFE, 8'h25, 1'b1);
        applyStimulus(18);
        checkOutput("reen_digit1", 8'hFD, 8'hF3, 1'b0);

`ifdef GPIO_SEG_SCAN_DIM_EN
        dim = 4'd3;
        applyStimulus(FRAME);
        dim = 4'd15;
        applyStimulus(FRAME);
        dim = 4'd0;
        applyStimulus(FRAME);
        dim = 4'd15;
`endif
        applyStimulus(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
